// File: rtl/uart_tx_buffered_pkg.sv
// Shared constants for the UART TX/RX slice: FSM encodings, frame geometry, baud default.
package uart_tx_buffered_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200
    localparam int DATA_BITS            = 8;
    localparam int FRAME_BITS           = 10;   // start + 8 data + stop

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte push handshake between the I/O execution unit (master) and the UART TX buffer (slave).
interface uart_tx_buffered_if;

    logic       en;
    logic [7:0] data_send;
    logic       rdy;

    modport master (output en, output data_send, input rdy);
    modport slave  (input en, input data_send, output rdy);

endinterface

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Single-clock FIFO with occupancy count; shared between the TX path and the future RX path.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    // Full/empty come from the registered count, so a push while full is
    // rejected even when a pop frees a slot on the same edge.
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

    assign dout  = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a baud-timed serialiser FSM.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset,
    uart_tx_buffered_if.slave   tx_if,
    output logic                busy,
    output logic                txd
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    tx_state_e         state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic              txd_q;

    logic [7:0]        fifo_dout;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              baud_term, pop;

    assign baud_term = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    // Pop from IDLE, or at the end of a stop bit to chain frames with no idle gap.
    assign pop = !fifo_empty &&
                 ((state_q == ST_IDLE) || (state_q == ST_STOP && baud_term));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_if.en),
        .pop   (pop),
        .din   (tx_if.data_send),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    baud_q <= '0;
                    txd_q  <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q <= fifo_dout;
                        txd_q   <= 1'b0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_term) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        txd_q     <= shift_q[0];
                        state_q   <= ST_DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_term) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                            txd_q   <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            shift_q   <= shift_q >> 1;
                            txd_q     <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_term) begin
                        baud_q <= '0;
                        if (!fifo_empty) begin
                            shift_q <= fifo_dout;
                            txd_q   <= 1'b0;
                            state_q <= ST_START;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_if.rdy = !fifo_full;
    assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);
    assign txd       = txd_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: a serial monitor decodes every txd frame against queued bytes.
module tb_uart_tx_buffered;
    import uart_tx_buffered_pkg::*;

    localparam int CPB       = 4;
    localparam int DEPTH     = 4;
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy, txd;

    uart_tx_buffered_if tx_if();

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tx_if (tx_if),
        .busy  (busy),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] sb[$];
    int         starts[$];
    logic       mon_busy = 1'b0;

    logic [FRAME_CYC-1:0] mon_s;
    logic                 mon_abort, mon_shape_ok;
    logic [7:0]           mon_byte, mon_exp;

    // Serial monitor: captures each frame cycle-by-cycle and checks bit timing and payload.
    always begin
        @(negedge clk);
        if (!reset && txd === 1'b0) begin
            mon_busy  = 1'b1;
            mon_abort = 1'b0;
            starts.push_back(cyc);
            mon_s     = '1;
            mon_s[0]  = txd;
            for (int i = 1; i < FRAME_CYC; i++) begin
                @(negedge clk);
                if (reset) begin
                    mon_abort = 1'b1;
                    break;
                end
                mon_s[i] = txd;
            end
            if (!mon_abort) begin
                mon_shape_ok = 1'b1;
                for (int b = 0; b < FRAME_BITS; b++)
                    for (int k = 1; k < CPB; k++)
                        if (mon_s[b*CPB+k] !== mon_s[b*CPB]) mon_shape_ok = 1'b0;
                if (mon_s[(FRAME_BITS-1)*CPB] !== 1'b1) mon_shape_ok = 1'b0;
                for (int b = 0; b < 8; b++) mon_byte[b] = mon_s[(b+1)*CPB];
                n_checks++;
                if (mon_shape_ok) n_pass++;
                else $display("FAIL frame_shape: samples=%b, required %0d-cycle bits, start 0, stop 1", mon_s, CPB);
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL frame_data: got %h, required no frame", mon_byte);
                end else begin
                    mon_exp = sb.pop_front();
                    if (mon_byte !== mon_exp)
                        $display("FAIL frame_data: got %h, required %h", mon_byte, mon_exp);
                    else n_pass++;
                end
            end
            mon_busy = 1'b0;
        end
    end

    task automatic wait_idle(input int max_cyc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && !mon_busy) done = 1'b1;
        end
        n_checks++;
        if (done) n_pass++;
        else $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, max_cyc);
    endtask

    task automatic test_reset();
        bit ok;
        tx_if.en = 1'b0;
        tx_if.data_send = 'x;
        reset = 1'b1;
        #1;
        n_checks++;
        if (txd !== 1'b1 || tx_if.rdy !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_in: txd=%b rdy=%b busy=%b, required 1 1 0", txd, tx_if.rdy, busy);
        else n_pass++;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        ok = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (txd !== 1'b1 || tx_if.rdy !== 1'b1 || busy !== 1'b0) ok = 1'b0;
        end
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL reset_idle: txd=%b rdy=%b busy=%b, required 1 1 0 for 50 cycles", txd, tx_if.rdy, busy);
    endtask

    task automatic test_single();
        sb.push_back(8'hA5);
        @(negedge clk);
        tx_if.en = 1'b1;
        tx_if.data_send = 8'hA5;
        @(posedge clk) #1;
        n_checks++;
        if (txd !== 1'b1 || busy !== 1'b1)
            $display("FAIL single_push_edge: txd=%b busy=%b, required 1 1", txd, busy);
        else n_pass++;
        @(negedge clk);
        tx_if.en = 1'b0;
        tx_if.data_send = 'x;
        @(posedge clk) #1;
        n_checks++;
        if (txd !== 1'b0) $display("FAIL single_start: txd=%b, required 0", txd);
        else n_pass++;
        repeat (39) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || txd !== 1'b1)
            $display("FAIL single_stop: busy=%b txd=%b, required 1 1", busy, txd);
        else n_pass++;
        @(posedge clk) #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL single_busy_fall: busy=%b, required 0", busy);
        else n_pass++;
        wait_idle(20);
        n_checks++;
        if (sb.size() !== 0) $display("FAIL single_drain: %0d bytes left, required 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_burst();
        bit ok;
        ok = 1'b1;
        starts.delete();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (tx_if.rdy !== 1'b1) ok = 1'b0;
            tx_if.en = 1'b1;
            tx_if.data_send = 8'(i);
            sb.push_back(8'(i));
        end
        @(negedge clk);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL burst_rdy_hi: rdy dropped during first five pushes, required 1");
        n_checks++;
        if (tx_if.rdy !== 1'b0) $display("FAIL burst_full: rdy=%b, required 0", tx_if.rdy);
        else n_pass++;
        tx_if.data_send = 8'h06;
        @(negedge clk);
        tx_if.en = 1'b0;
        tx_if.data_send = 'x;
        n_checks++;
        if (tx_if.rdy !== 1'b0) $display("FAIL burst_reject: rdy=%b, required 0", tx_if.rdy);
        else n_pass++;
        wait_idle(5 * FRAME_CYC + 50);
        ok = (starts.size() == 5);
        for (int i = 1; i < starts.size(); i++)
            if (starts[i] - starts[i-1] != FRAME_CYC) ok = 1'b0;
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL burst_gap: %0d frames, required 5 spaced %0d cycles", starts.size(), FRAME_CYC);
        n_checks++;
        if (sb.size() !== 0) $display("FAIL burst_drain: %0d bytes left, required 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_stop_edge_push();
        starts.delete();
        sb.push_back(8'h11);
        @(negedge clk);
        tx_if.en = 1'b1;
        tx_if.data_send = 8'h11;
        @(negedge clk);
        tx_if.en = 1'b0;
        tx_if.data_send = 'x;
        repeat (40) @(posedge clk);
        @(negedge clk);
        tx_if.en = 1'b1;
        tx_if.data_send = 8'h3C;
        sb.push_back(8'h3C);
        @(posedge clk) #1;
        n_checks++;
        if (txd !== 1'b1 || busy !== 1'b1)
            $display("FAIL stopedge_idle: txd=%b busy=%b, required 1 1", txd, busy);
        else n_pass++;
        @(negedge clk);
        tx_if.en = 1'b0;
        tx_if.data_send = 'x;
        @(posedge clk) #1;
        n_checks++;
        if (txd !== 1'b0) $display("FAIL stopedge_start: txd=%b, required 0", txd);
        else n_pass++;
        wait_idle(FRAME_CYC + 20);
        n_checks++;
        if (starts.size() != 2 || starts[1] - starts[0] != FRAME_CYC + 1)
            $display("FAIL stopedge_gap: %0d frames, required 2 spaced %0d cycles", starts.size(), FRAME_CYC + 1);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        tx_if.en = 1'b1;
        tx_if.data_send = 8'hFF;
        @(negedge clk);
        tx_if.en = 1'b0;
        tx_if.data_send = 'x;
        repeat (18) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (txd !== 1'b1 || busy !== 1'b0 || tx_if.rdy !== 1'b1)
            $display("FAIL reset_mid: txd=%b busy=%b rdy=%b, required 1 0 1", txd, busy, tx_if.rdy);
        else n_pass++;
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        sb.push_back(8'h00);
        @(negedge clk);
        tx_if.en = 1'b1;
        tx_if.data_send = 8'h00;
        @(negedge clk);
        tx_if.en = 1'b0;
        tx_if.data_send = 'x;
        wait_idle(FRAME_CYC + 20);
        n_checks++;
        if (sb.size() !== 0) $display("FAIL reset_mid_drain: %0d bytes left, required 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_held();
        bit ok;
        starts.delete();
        @(negedge clk);
        tx_if.en = 1'b1;
        tx_if.data_send = 8'h41;
        repeat (3) sb.push_back(8'h41);
        repeat (3) @(posedge clk);
        @(negedge clk);
        tx_if.en = 1'b0;
        tx_if.data_send = 'x;
        wait_idle(3 * FRAME_CYC + 30);
        ok = (starts.size() == 3);
        for (int i = 1; i < starts.size(); i++)
            if (starts[i] - starts[i-1] != FRAME_CYC) ok = 1'b0;
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL held_frames: %0d frames, required 3 spaced %0d cycles", starts.size(), FRAME_CYC);
        n_checks++;
        if (sb.size() !== 0) $display("FAIL held_drain: %0d bytes left, required 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_stop_edge_push();
        test_reset_mid();
        test_held();
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
